// File: rtl/pcie_us_axi_dma_wr_desc_arb.sv
// Two-port round-robin write-descriptor arbiter with status demux for the PCIe US AXI DMA engine.
// Optional per-port in-flight limit: define PCIE_DMA_DESC_ARB_OUTSTANDING_LIMIT_EN.
module pcie_us_axi_dma_wr_desc_arb #(
  parameter int unsigned PCIE_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned S_TAG_WIDTH     = 7,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic [PCIE_ADDR_WIDTH-1:0] s0_axis_write_desc_pcie_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0]  s0_axis_write_desc_axi_addr_i,
  input  logic [LEN_WIDTH-1:0]       s0_axis_write_desc_len_i,
  input  logic [S_TAG_WIDTH-1:0]     s0_axis_write_desc_tag_i,
  input  logic                       s0_axis_write_desc_valid_i,
  output logic                       s0_axis_write_desc_ready_o,

  input  logic [PCIE_ADDR_WIDTH-1:0] s1_axis_write_desc_pcie_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0]  s1_axis_write_desc_axi_addr_i,
  input  logic [LEN_WIDTH-1:0]       s1_axis_write_desc_len_i,
  input  logic [S_TAG_WIDTH-1:0]     s1_axis_write_desc_tag_i,
  input  logic                       s1_axis_write_desc_valid_i,
  output logic                       s1_axis_write_desc_ready_o,

  output logic [PCIE_ADDR_WIDTH-1:0] m_axis_write_desc_pcie_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axis_write_desc_axi_addr_o,
  output logic [LEN_WIDTH-1:0]       m_axis_write_desc_len_o,
  output logic [S_TAG_WIDTH:0]       m_axis_write_desc_tag_o,
  output logic                       m_axis_write_desc_valid_o,
  input  logic                       m_axis_write_desc_ready_i,

  input  logic [S_TAG_WIDTH:0]       s_axis_write_desc_status_tag_i,
  input  logic                       s_axis_write_desc_status_valid_i,

  output logic [S_TAG_WIDTH-1:0]     m0_axis_write_desc_status_tag_o,
  output logic                       m0_axis_write_desc_status_valid_o,
  output logic [S_TAG_WIDTH-1:0]     m1_axis_write_desc_status_tag_o,
  output logic                       m1_axis_write_desc_status_valid_o
);

  logic [PCIE_ADDR_WIDTH-1:0] pcie_addr_q, pcie_addr_d;
  logic [AXI_ADDR_WIDTH-1:0]  axi_addr_q, axi_addr_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [S_TAG_WIDTH:0]       tag_q, tag_d;
  logic                       valid_q, valid_d;
  // Port that wins when both are eligible.
  logic                       pref_q, pref_d;

  logic [S_TAG_WIDTH-1:0]     st0_tag_q, st0_tag_d, st1_tag_q, st1_tag_d;
  logic                       st0_valid_q, st0_valid_d, st1_valid_q, st1_valid_d;

  logic load_en, elig0, elig1, grant0, grant1, mask0, mask1;
  logic st_port, st0_evt, st1_evt;

  assign st_port = s_axis_write_desc_status_tag_i[S_TAG_WIDTH];
  assign st0_evt = s_axis_write_desc_status_valid_i && !st_port;
  assign st1_evt = s_axis_write_desc_status_valid_i && st_port;

`ifdef PCIE_DMA_DESC_ARB_OUTSTANDING_LIMIT_EN
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  logic [CntW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  assign mask0 = (cnt0_q == CntMax);
  assign mask1 = (cnt1_q == CntMax);

  // Grant and completion in the same cycle cancel; completions never underflow.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0 && !st0_evt)                     cnt0_d = cnt0_q + 1'b1;
    else if (!grant0 && st0_evt && cnt0_q != 0) cnt0_d = cnt0_q - 1'b1;
    if (grant1 && !st1_evt)                     cnt1_d = cnt1_q + 1'b1;
    else if (!grant1 && st1_evt && cnt1_q != 0) cnt1_d = cnt1_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
`else
  assign mask0 = 1'b0;
  assign mask1 = 1'b0;
`endif

  assign load_en = !valid_q || m_axis_write_desc_ready_i;
  assign elig0   = s0_axis_write_desc_valid_i && !mask0;
  assign elig1   = s1_axis_write_desc_valid_i && !mask1;

  // Readies are gated by reset so nothing is accepted while the block is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load_en && rst_ni) begin
      if (elig0 && elig1) begin
        grant0 = !pref_q;
        grant1 = pref_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign s0_axis_write_desc_ready_o = grant0;
  assign s1_axis_write_desc_ready_o = grant1;

  always_comb begin
    pcie_addr_d = pcie_addr_q;
    axi_addr_d  = axi_addr_q;
    len_d       = len_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    pref_d      = pref_q;
    if (grant0) begin
      pcie_addr_d = s0_axis_write_desc_pcie_addr_i;
      axi_addr_d  = s0_axis_write_desc_axi_addr_i;
      len_d       = s0_axis_write_desc_len_i;
      tag_d       = {1'b0, s0_axis_write_desc_tag_i};
      valid_d     = 1'b1;
      pref_d      = 1'b1;
    end else if (grant1) begin
      pcie_addr_d = s1_axis_write_desc_pcie_addr_i;
      axi_addr_d  = s1_axis_write_desc_axi_addr_i;
      len_d       = s1_axis_write_desc_len_i;
      tag_d       = {1'b1, s1_axis_write_desc_tag_i};
      valid_d     = 1'b1;
      pref_d      = 1'b0;
    end else if (load_en) begin
      valid_d     = 1'b0;
    end
  end

  always_comb begin
    st0_valid_d = st0_evt;
    st1_valid_d = st1_evt;
    st0_tag_d   = st0_evt ? s_axis_write_desc_status_tag_i[S_TAG_WIDTH-1:0] : st0_tag_q;
    st1_tag_d   = st1_evt ? s_axis_write_desc_status_tag_i[S_TAG_WIDTH-1:0] : st1_tag_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcie_addr_q <= '0;
      axi_addr_q  <= '0;
      len_q       <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      pref_q      <= 1'b0;
      st0_tag_q   <= '0;
      st1_tag_q   <= '0;
      st0_valid_q <= 1'b0;
      st1_valid_q <= 1'b0;
    end else begin
      pcie_addr_q <= pcie_addr_d;
      axi_addr_q  <= axi_addr_d;
      len_q       <= len_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      pref_q      <= pref_d;
      st0_tag_q   <= st0_tag_d;
      st1_tag_q   <= st1_tag_d;
      st0_valid_q <= st0_valid_d;
      st1_valid_q <= st1_valid_d;
    end
  end

  assign m_axis_write_desc_pcie_addr_o     = pcie_addr_q;
  assign m_axis_write_desc_axi_addr_o      = axi_addr_q;
  assign m_axis_write_desc_len_o           = len_q;
  assign m_axis_write_desc_tag_o           = tag_q;
  assign m_axis_write_desc_valid_o         = valid_q;
  assign m0_axis_write_desc_status_tag_o   = st0_tag_q;
  assign m0_axis_write_desc_status_valid_o = st0_valid_q;
  assign m1_axis_write_desc_status_tag_o   = st1_tag_q;
  assign m1_axis_write_desc_status_valid_o = st1_valid_q;

endmodule
